// File: rtl/alu_iter_unit.sv
// Multi-cycle ALU: 16 base ops in one cycle, iterative MUL and bit-serial shifts.
// Latency: base/reserved/zero-shift ops 0 extra cycles, shift by s takes s cycles, MUL takes WIDTH cycles.
// Backpressure: Start is ignored while Busy=1. Optional multiplier is built only when ALU_MUL_EN is defined.
module alu_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [4:0]         FunSel,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               WF,
   output logic               Busy,
   output logic               Done,
   output logic [WIDTH-1:0]   ALUOut,
   output logic [3:0]         FlagsOut
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;
   localparam int M  = WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             wf_q, wf_n;
   logic [1:0]       kind_q, kind_n;
   logic [WIDTH-1:0] sh_q, sh_n;
   logic [WIDTH-1:0] out_n;
   logic [3:0]       flags_n;
   logic             done_n;

   logic [3:0]       f;
   logic [SW-1:0]    s;
   logic             add_cin;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] b_res, step;
   logic             b_c, b_o, b_setc, b_seto, step_c;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod, prod_n, mcand, mcand_n, prod_step;
   logic [WIDTH-1:0]   mplier, mplier_n;
`endif

   assign f    = FunSel[3:0];
   assign s    = B[SW-1:0];
   assign Busy = (state != S_IDLE);

   always_comb begin
      add_cin = (f == 4'd5) ? FlagsOut[2] : 1'b0;
      sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, add_cin};
      diff    = {1'b0, A} - {1'b0, B};
      b_res   = A;
      b_c     = 1'b0;
      b_o     = 1'b0;
      b_setc  = 1'b0;
      b_seto  = 1'b0;
      case (f)
         4'd0:  b_res = A;
         4'd1:  b_res = B;
         4'd2:  b_res = ~A;
         4'd3:  b_res = ~B;
         4'd4, 4'd5: begin
            b_res = sum[M:0]; b_c = sum[WIDTH]; b_setc = 1'b1; b_seto = 1'b1;
            b_o   = (A[M] == B[M]) && (sum[M] != A[M]);
         end
         4'd6: begin
            // C is the inverted borrow: set when A >= B unsigned
            b_res = diff[M:0]; b_c = ~diff[WIDTH]; b_setc = 1'b1; b_seto = 1'b1;
            b_o   = (A[M] != B[M]) && (diff[M] != A[M]);
         end
         4'd7:  b_res = A & B;
         4'd8:  b_res = A | B;
         4'd9:  b_res = A ^ B;
         4'd10: b_res = ~(A & B);
         4'd11: begin b_res = {A[M-1:0], 1'b0};         b_c = A[M]; b_setc = 1'b1; end
         4'd12: begin b_res = {1'b0, A[M:1]};           b_c = A[0]; b_setc = 1'b1; end
         4'd13: begin b_res = {A[M], A[M:1]};           b_c = A[0]; b_setc = 1'b1; end
         4'd14: begin b_res = {A[M-1:0], FlagsOut[2]};  b_c = A[M]; b_setc = 1'b1; end
         4'd15: begin b_res = {FlagsOut[2], A[M:1]};    b_c = A[0]; b_setc = 1'b1; end
      endcase
   end

   always_comb begin
      case (kind_q)
         2'd2:    begin step = {1'b0, sh_q[M:1]};    step_c = sh_q[0]; end
         2'd3:    begin step = {sh_q[M], sh_q[M:1]}; step_c = sh_q[0]; end
         default: begin step = {sh_q[M-1:0], 1'b0};  step_c = sh_q[M]; end
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wf_n    = wf_q;
      kind_n  = kind_q;
      sh_n    = sh_q;
      out_n   = ALUOut;
      flags_n = FlagsOut;
      done_n  = 1'b0;
`ifdef ALU_MUL_EN
      prod_n    = prod;
      mcand_n   = mcand;
      mplier_n  = mplier;
      prod_step = prod + (mplier[0] ? mcand : '0);
`endif
      case (state)
         S_IDLE: if (Start) begin
            if (!FunSel[4]) begin
               out_n  = b_res;
               done_n = 1'b1;
               if (WF)
                  flags_n = {b_res == '0, b_setc ? b_c : FlagsOut[2], b_res[M], b_seto ? b_o : FlagsOut[0]};
            end else begin
               case (f)
`ifdef ALU_MUL_EN
                  4'd0: begin
                     state_n  = S_MUL;
                     cnt_n    = CW'(WIDTH);
                     wf_n     = WF;
                     prod_n   = '0;
                     mcand_n  = {{WIDTH{1'b0}}, A};
                     mplier_n = B;
                  end
`endif
                  4'd1, 4'd2, 4'd3: begin
                     if (s == '0) begin
                        out_n  = A;
                        done_n = 1'b1;
                        if (WF) flags_n = {A == '0, FlagsOut[2], A[M], FlagsOut[0]};
                     end else begin
                        state_n = S_SHIFT;
                        cnt_n   = {1'b0, s};
                        wf_n    = WF;
                        kind_n  = f[1:0];
                        sh_n    = A;
                     end
                  end
                  default: begin
                     out_n  = A;
                     done_n = 1'b1;
                  end
               endcase
            end
         end
         S_SHIFT: begin
            sh_n  = step;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = S_IDLE;
               out_n   = step;
               done_n  = 1'b1;
               if (wf_q) flags_n = {step == '0, step_c, step[M], FlagsOut[0]};
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            prod_n   = prod_step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = S_IDLE;
               out_n   = prod_step[M:0];
               done_n  = 1'b1;
               if (wf_q)
                  flags_n = {prod_step[M:0] == '0, |prod_step[2*WIDTH-1:WIDTH], prod_step[M], FlagsOut[0]};
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         wf_q     <= 1'b0;
         kind_q   <= 2'd0;
         sh_q     <= '0;
         ALUOut   <= '0;
         FlagsOut <= '0;
         Done     <= 1'b0;
`ifdef ALU_MUL_EN
         prod     <= '0;
         mcand    <= '0;
         mplier   <= '0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         wf_q     <= wf_n;
         kind_q   <= kind_n;
         sh_q     <= sh_n;
         ALUOut   <= out_n;
         FlagsOut <= flags_n;
         Done     <= done_n;
`ifdef ALU_MUL_EN
         prod     <= prod_n;
         mcand    <= mcand_n;
         mplier   <= mplier_n;
`endif
      end
   end
endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit at WIDTH=32: vector table for single-cycle ops,
// hand sequences for shifts, MUL (when ALU_MUL_EN), back-to-back issue and mid-op reset.
module tb_alu_iter_unit;
   logic        Clock, Reset, Start, WF, Busy, Done;
   logic [4:0]  FunSel;
   logic [31:0] A, B, ALUOut;
   logic [3:0]  FlagsOut;

   int n_chk  = 0;
   int n_pass = 0;

   alu_iter_unit #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
      .A(A), .B(B), .WF(WF), .Busy(Busy), .Done(Done),
      .ALUOut(ALUOut), .FlagsOut(FlagsOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [4:0]  fs;
      logic [31:0] a;
      logic [31:0] b;
      logic        wf;
      logic [31:0] out;
      logic [3:0]  fl;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called just after a falling edge; returns just after the falling edge following E0.
   task automatic apply(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b, input logic wf);
      FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
   endtask

   task automatic check_single(input string nm, input logic [31:0] eo, input logic [3:0] ef);
      chk({nm, "_done"}, {31'd0, Done}, 32'd1);
      chk({nm, "_busy"}, {31'd0, Busy}, 32'd0);
      chk({nm, "_out"}, ALUOut, eo);
      chk({nm, "_flags"}, {28'd0, FlagsOut}, {28'd0, ef});
   endtask

   task automatic run_multi(input string nm, input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input bit pulse, input logic [31:0] eo, input logic [3:0] ef);
      int k;
      bit busy_ok;
      apply(fs, a, b, 1'b1);
      k = 0;
      busy_ok = 1'b1;
      while (!Done && k < 100) begin
         if (!Busy) busy_ok = 1'b0;
         if (pulse && k == 4) begin
            Start = 1'b1; FunSel = 5'h04; A = 32'd1; B = 32'd1;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clock);
         @(negedge Clock);
         k++;
      end
      Start = 1'b0;
      chk({nm, "_latency"}, k, lat);
      chk({nm, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
      chk({nm, "_busy_end"}, {31'd0, Busy}, 32'd0);
      chk({nm, "_out"}, ALUOut, eo);
      chk({nm, "_flags"}, {28'd0, FlagsOut}, {28'd0, ef});
   endtask

   initial begin
      int k;
      bit saw_done;
      Reset = 1'b1; Start = 1'b0; FunSel = '0; A = '0; B = '0; WF = 1'b0;
      tbl[0]  = '{5'h04, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b0011};
      tbl[1]  = '{5'h06, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 4'b1100};
      tbl[2]  = '{5'h05, 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 4'b0000};
      tbl[3]  = '{5'h04, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0000};
      tbl[4]  = '{5'h04, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b1100};
      tbl[5]  = '{5'h00, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0110};
      tbl[6]  = '{5'h06, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 4'b0010};
      tbl[7]  = '{5'h07, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 4'b0010};
      tbl[8]  = '{5'h09, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 4'b1000};
      tbl[9]  = '{5'h03, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b0010};
      tbl[10] = '{5'h06, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0101};
      tbl[11] = '{5'h0B, 32'h80000001, 32'h00000000, 1'b1, 32'h00000002, 4'b0101};
      tbl[12] = '{5'h0F, 32'h00000002, 32'h00000000, 1'b1, 32'h80000001, 4'b0011};
      tbl[13] = '{5'h0E, 32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 4'b1101};
      tbl[14] = '{5'h0D, 32'h80000000, 32'h00000000, 1'b1, 32'hC0000000, 4'b0011};
      tbl[15] = '{5'h0C, 32'h00000003, 32'h00000000, 1'b1, 32'h00000001, 4'b0101};
      tbl[16] = '{5'h15, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 4'b0101};
      tbl[17] = '{5'h11, 32'h12345678, 32'hFFFFFFE0, 1'b1, 32'h12345678, 4'b0101};
      tbl[18] = '{5'h02, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b0111};
      tbl[19] = '{5'h01, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b1101};
      tbl[20] = '{5'h08, 32'h0000000F, 32'h000000F0, 1'b1, 32'h000000FF, 4'b0101};
      tbl[21] = '{5'h0A, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b1101};

      repeat (2) @(negedge Clock);
      chk("reset_out", ALUOut, 32'd0);
      chk("reset_flags", {28'd0, FlagsOut}, 32'd0);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
      Reset = 1'b0;
      @(negedge Clock);

      for (int i = 0; i < 22; i++) begin
         apply(tbl[i].fs, tbl[i].a, tbl[i].b, tbl[i].wf);
         check_single($sformatf("vec%0d", i), tbl[i].out, tbl[i].fl);
      end
      @(posedge Clock);
      @(negedge Clock);
      chk("done_one_cycle", {31'd0, Done}, 32'd0);
      chk("idle_busy", {31'd0, Busy}, 32'd0);

      run_multi("shl4", 5'h11, 32'h8000000F, 32'd4, 4, 1'b0, 32'h000000F0, 4'b0001);
      run_multi("shr3", 5'h12, 32'h000000F5, 32'd3, 3, 1'b0, 32'h0000001E, 4'b0101);
      run_multi("sar31", 5'h13, 32'h80000000, 32'd31, 31, 1'b1, 32'hFFFFFFFF, 4'b0011);
`ifdef ALU_MUL_EN
      run_multi("mul", 5'h10, 32'h00010000, 32'h00010000, 32, 1'b1, 32'h00000000, 4'b1101);
`else
      apply(5'h10, 32'hCAFEF00D, 32'h00000003, 1'b1);
      check_single("ext0_reserved", 32'hCAFEF00D, 4'b0011);
`endif
      apply(5'h04, 32'd2, 32'd3, 1'b1);
      check_single("back_to_back_add", 32'd5, 4'b0000);
      @(negedge Clock);

`ifdef ALU_MUL_EN
      apply(5'h10, 32'h00000003, 32'h00000005, 1'b1);
`else
      apply(5'h11, 32'h00000001, 32'd31, 1'b1);
`endif
      repeat (9) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      chk("midreset_out", ALUOut, 32'd0);
      chk("midreset_flags", {28'd0, FlagsOut}, 32'd0);
      chk("midreset_busy", {31'd0, Busy}, 32'd0);
      chk("midreset_done", {31'd0, Done}, 32'd0);
      saw_done = 1'b0;
      for (k = 0; k < 40; k++) begin
         @(negedge Clock);
         if (Done || Busy) saw_done = 1'b1;
      end
      chk("midreset_aborted", {31'd0, saw_done}, 32'd0);
      apply(5'h04, 32'h7FFFFFFF, 32'h00000001, 1'b1);
      check_single("post_reset_add", 32'h80000000, 4'b0011);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
